// File: rtl/stall_sched.sv
// stall_sched: registered stall/flush scheduler for the 5-stage core.
// Handles flush requests, multi-cycle multiply/divide occupancy of EX
// (with a divide timeout) and single-cycle load-use bubbles.
// Optional feature macro: STALL_SCHED_LOAD_USE_EN enables load-use
// detection; when undefined the load-use term is tied to 0.
module stall_sched #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_TIMEOUT = 64,
    localparam int StallBus   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                id_rs_re,
    input  logic                id_rt_re,
    input  logic                ex_is_load,
    input  logic                ex_we,
    input  logic [4:0]          ex_wreg,
    input  logic                md_start,
    input  logic                md_is_div,
    input  logic                div_ready,
    input  logic                flush_req,
    output logic [StallBus-1:0] stall,
    output logic                bubble_ex,
    output logic                flush,
    output logic                md_done,
    output logic                md_err,
    output logic                md_busy
);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_MD_WAIT = 1'b1;

    // PC/IF/ID/EX held while EX is occupied; PC/IF/ID held for load-use.
    localparam logic [StallBus-1:0] STALL_MD = 6'b001111;
    localparam logic [StallBus-1:0] STALL_LU = 6'b000111;

    // Counter reload values; the counter runs down to 0 inside MD_WAIT.
    localparam logic [6:0] MUL_LOAD = 7'(MULT_CYCLES - 1);
    localparam logic [6:0] DIV_LOAD = 7'(DIV_TIMEOUT - 1);

    logic [0:0]          state_q, state_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                is_div_q, is_div_d;

    logic                load_use;
    logic [StallBus-1:0] stall_c;
    logic                bubble_c, flush_c, done_c, err_c;

`ifdef STALL_SCHED_LOAD_USE_EN
    assign load_use = ex_is_load && ex_we && (ex_wreg != 5'd0) &&
                      ((id_rs_re && (id_rs == ex_wreg)) ||
                       (id_rt_re && (id_rt == ex_wreg)));
`else
    // Load data reaches consumers through MEM forwarding only.
    logic lu_unused;
    assign load_use  = 1'b0;
    assign lu_unused = ^{id_rs, id_rt, id_rs_re, id_rt_re, ex_is_load, ex_we, ex_wreg};
`endif

    // Priority: flush, then MD_WAIT sequencing, then md issue, then load-use.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        stall_c  = '0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        done_c   = 1'b0;
        err_c    = 1'b0;
        if (flush_req) begin
            // Abandons any in-flight multiply/divide without a pulse.
            flush_c = 1'b1;
            state_d = S_RUN;
        end else if (state_q == S_MD_WAIT) begin
            if (is_div_q ? div_ready : (cnt_q == 7'd0)) begin
                done_c  = 1'b1;
                state_d = S_RUN;
            end else if (is_div_q && (cnt_q == 7'd0)) begin
                err_c   = 1'b1;
                state_d = S_RUN;
            end else begin
                stall_c = STALL_MD;
                cnt_d   = cnt_q - 7'd1;
            end
        end else if (md_start) begin
            if (!md_is_div && (MULT_CYCLES == 1)) begin
                // Single-cycle multiply completes without occupying EX further.
                done_c = 1'b1;
            end else begin
                stall_c  = STALL_MD;
                state_d  = S_MD_WAIT;
                is_div_d = md_is_div;
                cnt_d    = md_is_div ? DIV_LOAD : MUL_LOAD;
            end
        end else if (load_use) begin
            stall_c  = STALL_LU;
            bubble_c = 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        stall     = rst ? '0   : stall_c;
        bubble_ex = rst ? 1'b0 : bubble_c;
        flush     = rst ? 1'b0 : flush_c;
        md_done   = rst ? 1'b0 : done_c;
        md_err    = rst ? 1'b0 : err_c;
        md_busy   = rst ? 1'b0 : (state_q == S_MD_WAIT);
    end

    // State, counter and divide flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            cnt_q    <= 7'd0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

endmodule

// File: tb/tb_stall_sched.sv
// Self-checking bench for stall_sched: directed scenarios with constant
// expectations plus a randomized run against a cycle-timestamp model.
module tb_stall_sched;

    localparam int M = 4;
    localparam int D = 64;

    logic       clk = 1'b0;
    logic       rst, id_rs_re, id_rt_re, ex_is_load, ex_we;
    logic [4:0] id_rs, id_rt, ex_wreg;
    logic       md_start, md_is_div, div_ready, flush_req;
    logic [5:0] stall;
    logic       bubble_ex, flush, md_done, md_err, md_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: an operation is remembered by its issue cycle; age decides outcome.
    bit  m_busy = 0, n_busy;
    bit  m_div  = 0, n_div;
    int  m_t0   = 0, n_t0;
    logic [10:0] e_vec, g_vec;
    logic [5:0]  g_stall;
    logic        g_bub, g_flush, g_done, g_err, g_busy;

    always #5 clk = ~clk;

    stall_sched #(.MULT_CYCLES(M), .DIV_TIMEOUT(D)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_wreg(ex_wreg),
        .md_start(md_start), .md_is_div(md_is_div), .div_ready(div_ready),
        .flush_req(flush_req),
        .stall(stall), .bubble_ex(bubble_ex), .flush(flush),
        .md_done(md_done), .md_err(md_err), .md_busy(md_busy)
    );

    function automatic logic model_luse();
`ifdef STALL_SCHED_LOAD_USE_EN
        return ex_is_load && ex_we && ex_wreg != 0 &&
               ((id_rs_re && id_rs == ex_wreg) || (id_rt_re && id_rt == ex_wreg));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_eval();
        logic [5:0] s = '0;
        logic b = 0, f = 0, d = 0, er = 0;
        int age = cyc - m_t0;
        n_busy = m_busy; n_t0 = m_t0; n_div = m_div;
        if (rst) begin
            n_busy = 0;
        end else if (flush_req) begin
            f = 1; n_busy = 0;
        end else if (m_busy) begin
            if (m_div ? div_ready : (age == M)) begin d = 1; n_busy = 0; end
            else if (m_div && age == D)          begin er = 1; n_busy = 0; end
            else s = 6'b001111;
        end else if (md_start) begin
            if (!md_is_div && M == 1) d = 1;
            else begin s = 6'b001111; n_busy = 1; n_t0 = cyc; n_div = md_is_div; end
        end else if (model_luse()) begin
            s = 6'b000111; b = 1;
        end
        e_vec = {s, b, f, d, er, m_busy && !rst};
    endtask

    // One clock: sample outputs mid-cycle, advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        g_stall = stall; g_bub = bubble_ex; g_flush = flush;
        g_done = md_done; g_err = md_err; g_busy = md_busy;
        g_vec = {stall, bubble_ex, flush, md_done, md_err, md_busy};
        model_eval();
        @(posedge clk);
        m_busy = n_busy; m_t0 = n_t0; m_div = n_div;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; id_rs = 0; id_rt = 0; id_rs_re = 0; id_rt_re = 0;
        ex_is_load = 0; ex_we = 0; ex_wreg = 0;
        md_start = 0; md_is_div = 0; div_ready = 0; flush_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1; md_start = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); checks++;
            if (g_vec !== 11'd0) begin errors++; $display("FAIL reset_quiet: got %b expected 0", g_vec); end
        end
        idle_inputs(); tick(); checks++;
        if (g_busy !== 1'b0 || g_stall !== 6'd0) begin
            errors++; $display("FAIL reset_release: busy=%b stall=%b expected 0/000000", g_busy, g_stall);
        end
    endtask

    task automatic test_mult();
        idle_inputs(); md_start = 1; md_is_div = 0;
        tick(); checks++;
        if (g_stall !== 6'b001111 || g_busy !== 1'b0) begin
            errors++; $display("FAIL mult_issue: stall=%b busy=%b expected 001111/0", g_stall, g_busy);
        end
        md_start = 0;
        for (int i = 1; i < M; i++) begin
            tick(); checks++;
            if (g_stall !== 6'b001111 || g_done !== 1'b0) begin
                errors++; $display("FAIL mult_stall: stall=%b done=%b expected 001111/0", g_stall, g_done);
            end
        end
        tick(); checks++;
        if (g_done !== 1'b1 || g_stall !== 6'd0) begin
            errors++; $display("FAIL mult_done: done=%b stall=%b expected 1/000000", g_done, g_stall);
        end
        tick(); checks++;
        if (g_busy !== 1'b0 || g_done !== 1'b0) begin
            errors++; $display("FAIL mult_idle: busy=%b done=%b expected 0/0", g_busy, g_done);
        end
    endtask

    task automatic test_div();
        idle_inputs(); md_start = 1; md_is_div = 1;
        tick(); md_start = 0;
        for (int i = 1; i < 10; i++) begin
            tick(); checks++;
            if (g_stall !== 6'b001111) begin errors++; $display("FAIL div_stall: stall=%b expected 001111", g_stall); end
        end
        div_ready = 1; tick(); checks++;
        if (g_done !== 1'b1 || g_stall !== 6'd0 || g_err !== 1'b0) begin
            errors++; $display("FAIL div_done: done=%b stall=%b err=%b expected 1/000000/0", g_done, g_stall, g_err);
        end
        div_ready = 0; tick();
        // div_ready already high at issue is only sampled one cycle later.
        md_start = 1; md_is_div = 1; div_ready = 1;
        tick(); checks++;
        if (g_stall !== 6'b001111 || g_done !== 1'b0) begin
            errors++; $display("FAIL div_early_ready: stall=%b done=%b expected 001111/0", g_stall, g_done);
        end
        md_start = 0; tick(); checks++;
        if (g_done !== 1'b1 || g_stall !== 6'd0) begin
            errors++; $display("FAIL div_next_cycle: done=%b stall=%b expected 1/000000", g_done, g_stall);
        end
        idle_inputs(); tick();
    endtask

    task automatic test_div_timeout();
        int bad = 0;
        idle_inputs(); md_start = 1; md_is_div = 1;
        tick(); md_start = 0;
        for (int i = 1; i < D; i++) begin
            tick();
            if (g_stall !== 6'b001111 || g_err !== 1'b0 || g_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL timeout_wait: %0d bad cycles expected 0", bad); end
        tick(); checks++;
        if (g_err !== 1'b1 || g_done !== 1'b0 || g_stall !== 6'd0) begin
            errors++; $display("FAIL timeout_err: err=%b done=%b stall=%b expected 1/0/000000", g_err, g_done, g_stall);
        end
        tick(); checks++;
        if (g_busy !== 1'b0 || g_err !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: busy=%b err=%b expected 0/0", g_busy, g_err);
        end
    endtask

    task automatic test_load_use();
        logic [5:0] exp_s;
        logic       exp_b;
`ifdef STALL_SCHED_LOAD_USE_EN
        exp_s = 6'b000111; exp_b = 1'b1;
`else
        exp_s = 6'b000000; exp_b = 1'b0;
`endif
        idle_inputs(); ex_is_load = 1; ex_we = 1; ex_wreg = 8; id_rs = 8; id_rs_re = 1;
        tick(); checks++;
        if (g_stall !== exp_s || g_bub !== exp_b) begin
            errors++; $display("FAIL load_use_rs: stall=%b bubble=%b expected %b/%b", g_stall, g_bub, exp_s, exp_b);
        end
        id_rs_re = 0; id_rs = 3; id_rt = 8; id_rt_re = 1;
        tick(); checks++;
        if (g_stall !== exp_s || g_bub !== exp_b) begin
            errors++; $display("FAIL load_use_rt: stall=%b bubble=%b expected %b/%b", g_stall, g_bub, exp_s, exp_b);
        end
        ex_wreg = 0; id_rt = 0;
        tick(); checks++;
        if (g_stall !== 6'd0 || g_bub !== 1'b0) begin
            errors++; $display("FAIL load_use_r0: stall=%b bubble=%b expected 000000/0", g_stall, g_bub);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs(); md_start = 1; md_is_div = 1;
        tick(); md_start = 0; tick(); tick();
        flush_req = 1; tick(); checks++;
        if (g_flush !== 1'b1 || g_stall !== 6'd0 || g_done !== 1'b0 || g_err !== 1'b0) begin
            errors++; $display("FAIL flush_mid_div: flush=%b stall=%b done=%b err=%b expected 1/000000/0/0",
                               g_flush, g_stall, g_done, g_err);
        end
        flush_req = 0; div_ready = 1; tick(); checks++;
        if (g_done !== 1'b0 || g_busy !== 1'b0 || g_stall !== 6'd0 || g_flush !== 1'b0) begin
            errors++; $display("FAIL flush_late_ready: done=%b busy=%b stall=%b flush=%b expected 0/0/000000/0",
                               g_done, g_busy, g_stall, g_flush);
        end
        // Reset in the middle of a divide: back to RUN silently.
        idle_inputs(); md_start = 1; md_is_div = 1;
        tick(); md_start = 0; tick();
        rst = 1; tick(); checks++;
        if (g_vec !== 11'd0) begin errors++; $display("FAIL reset_mid_div: got %b expected 0", g_vec); end
        rst = 0; div_ready = 1; tick(); checks++;
        if (g_busy !== 1'b0 || g_done !== 1'b0 || g_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid_div_after: busy=%b done=%b err=%b expected 0/0/0", g_busy, g_done, g_err);
        end
        idle_inputs();
    endtask

    task automatic test_precedence();
        idle_inputs(); ex_is_load = 1; ex_we = 1; ex_wreg = 5; id_rs = 5; id_rs_re = 1;
        flush_req = 1; tick(); checks++;
        if (g_stall !== 6'd0 || g_bub !== 1'b0 || g_flush !== 1'b1) begin
            errors++; $display("FAIL prec_flush_lu: stall=%b bubble=%b flush=%b expected 000000/0/1", g_stall, g_bub, g_flush);
        end
        flush_req = 0; md_start = 1; md_is_div = 0;
        tick(); checks++;
        if (g_stall !== 6'b001111 || g_bub !== 1'b0) begin
            errors++; $display("FAIL prec_md_lu: stall=%b bubble=%b expected 001111/0", g_stall, g_bub);
        end
        idle_inputs();
        for (int i = 1; i < M; i++) tick();
        tick(); checks++;
        if (g_done !== 1'b1) begin errors++; $display("FAIL prec_md_done: done=%b expected 1", g_done); end
        tick();
    endtask

    task automatic test_random();
        int bad = 0, ready_pct;
        for (int i = 0; i < 3000; i++) begin
            ready_pct  = ((i / 500) % 2 == 0) ? 16 : 1;
            rst        = ($urandom_range(99) == 0);
            flush_req  = ($urandom_range(29) == 0);
            md_start   = ($urandom_range(7) == 0);
            md_is_div  = $urandom_range(1);
            div_ready  = ($urandom_range(99) < ready_pct);
            ex_is_load = $urandom_range(1);
            ex_we      = ($urandom_range(3) != 0);
            ex_wreg    = 5'($urandom_range(3));
            id_rs      = 5'($urandom_range(3));
            id_rt      = 5'($urandom_range(3));
            id_rs_re   = $urandom_range(1);
            id_rt_re   = $urandom_range(1);
            tick(); checks++;
            if (g_vec !== e_vec) begin
                errors++; bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d: got %b expected %b (stall,bub,flush,done,err,busy)", cyc, g_vec, e_vec);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_mult();
        test_div();
        test_div_timeout();
        test_load_use();
        test_flush();
        test_precedence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
